oam_dma: RTL

- CPU-side bus initiator for sprite OAM transfers. A CPU write to $4014 starts it.
- Halts the CPU through RDY, then takes the CPU bus and copies 256 bytes from CPU page $XX00-$XXFF.
- Each byte is written to the PPU OAM data register ($2004) through the PPU's CPU register port, so it is the master driving that port.
- Sits between the CPU core, the CPU bus mux and the PPU register interface.

---
 rtl/oam_dma.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/oam_dma.sv
// Sprite OAM DMA engine: halts the CPU, takes the CPU bus and copies one
// page of CPU memory into the PPU OAM data register, one get/put pair per byte.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | CPU owns the bus, waiting for a $4014 write
// S_HALT  | RDY low, waiting for the CPU to reach a read cycle
// S_ALIGN | one dummy cycle so the first get lands on an even (PAR=0) cycle
// S_READ  | get: read {page, idx} from the CPU bus
// S_WRITE | put: write the fetched byte to OAM_REG, advance idx
module oam_dma #(
  parameter logic [15:0] OAM_REG  = 16'h2004,
  parameter int          XFER_LEN = 256
) (
  input  logic        CPUCLK,
  input  logic        RST,
  input  logic        DMA_REQ,
  input  logic [7:0]  CPUDI,
  input  logic        CPU_RW,
  output logic        RDY,
  output logic        DMA_EN,
  output logic [15:0] DMA_A,
  output logic        DMA_RW,
  output logic [7:0]  DMA_DO,
  input  logic [7:0]  DMA_DI,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  // idx is 8 bits wide and only ever wraps; it never carries into the page.
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t      state_q, state_d;
  logic        par_q, par_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  page_q, page_d;
  logic        rdy_q, rdy_d;
  logic        dma_en_q, dma_en_d;
  logic        dma_rw_q, dma_rw_d;
  logic [15:0] dma_a_q, dma_a_d;
  logic [7:0]  dma_do_q, dma_do_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Next-state and next-output logic; outputs are decoded from the next state
  // so every bus signal comes straight from a flop in the cycle it applies to.
  always_comb begin
    state_d  = state_q;
    par_d    = ~par_q;
    idx_d    = idx_q;
    page_d   = page_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dma_a_d  = dma_a_q;
    dma_do_d = dma_do_q;

    case (state_q)
      S_IDLE: begin
        if (DMA_REQ) begin
          page_d  = CPUDI;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        // The CPU only stops on a read; the first read cycle here is the halt
        // cycle, and its parity decides whether an extra align cycle is needed.
        if (CPU_RW) state_d = par_q ? S_READ : S_ALIGN;
      end
      S_ALIGN: begin
        state_d = S_READ;
      end
      S_READ: begin
        // The fetched byte is captured straight into the write-data flop.
        dma_do_d = DMA_DI;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        idx_d = idx_q + 8'd1;
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_READ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rdy_d    = (state_d == S_IDLE);
    dma_en_d = (state_d == S_READ) || (state_d == S_WRITE);
    dma_rw_d = (state_d != S_WRITE);
    if (state_d == S_READ)  dma_a_d = {page_d, idx_d};
    if (state_d == S_WRITE) dma_a_d = OAM_REG;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CPUCLK) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      par_q    <= 1'b0;
      idx_q    <= '0;
      page_q   <= '0;
      rdy_q    <= 1'b1;
      dma_en_q <= 1'b0;
      dma_rw_q <= 1'b1;
      dma_a_q  <= '0;
      dma_do_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      par_q    <= par_d;
      idx_q    <= idx_d;
      page_q   <= page_d;
      rdy_q    <= rdy_d;
      dma_en_q <= dma_en_d;
      dma_rw_q <= dma_rw_d;
      dma_a_q  <= dma_a_d;
      dma_do_q <= dma_do_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign RDY    = rdy_q;
  assign DMA_EN = dma_en_q;
  assign DMA_RW = dma_rw_q;
  assign DMA_A  = dma_a_q;
  assign DMA_DO = dma_do_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule
